dcache_axi_responder: RTL and testbench

- Memory-side responder for the data cache's simplified AXI-style read/write channels; it is the other end of the cache's r_req/ret_* and w_req/w_data_*/b_* handshakes.
- Backs a word-addressed on-chip RAM and serves burst line fills, burst dirty-line writebacks and single-beat uncached accesses.
- Used as the memory model in cache-level simulation and as the on-chip RAM bridge in FPGA bring-up.

---
 rtl/dcache_axi_responder_pkg.sv | 19 +
 rtl/dcache_axi_responder_resp_ram.sv | 26 ++
 rtl/dcache_axi_responder.sv | 154 +++++++++++++++
 tb/tb_dcache_axi_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_axi_responder_pkg.sv
// Shared definitions for the data-cache memory-side responder: FSM encoding
// and the cache line geometry both ends of the AXI-style channels agree on.
package dcache_axi_responder_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_R_WAIT = 3'd1,
    S_R_BEAT = 3'd2,
    S_W_BEAT = 3'd3,
    S_B_WAIT = 3'd4,
    S_B_RESP = 3'd5
  } state_e;

  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam int         LINE_BEATS = 16;
  localparam logic [7:0] LINE_LEN   = 8'd15;
  localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/dcache_axi_responder_resp_ram.sv
// Word-addressed backing RAM: byte-enabled synchronous write, asynchronous read
// so a burst beat presents RAM[address] in the same cycle the address is held.
module resp_ram
  import dcache_axi_responder_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic                  clk,
  input  logic [WORD_BYTES-1:0] we,
  input  logic [AW-1:0]         waddr,
  input  logic [31:0]           wdata,
  input  logic [AW-1:0]         raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dcache_axi_responder.sv
// Memory-side responder for the data cache: serves burst refills, burst
// writebacks and single-beat uncached accesses from an on-chip RAM.
module dcache_axi_responder
  import dcache_axi_responder_pkg::*;
#(
  parameter int AW     = 12,
  parameter int RD_LAT = 2,
  parameter int B_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  r_req,
  input  logic [31:0]           r_addr,
  input  logic [2:0]            r_size,
  input  logic [7:0]            r_length,
  output logic                  r_rdy,
  input  logic                  r_data_ready,
  output logic                  ret_valid,
  output logic                  ret_last,
  output logic [31:0]           r_data,
  input  logic                  w_req,
  input  logic [31:0]           w_addr,
  input  logic [2:0]            w_size,
  input  logic [7:0]            w_length,
  output logic                  w_rdy,
  input  logic                  w_data_req,
  input  logic [31:0]           w_data,
  input  logic [WORD_BYTES-1:0] w_strb,
  input  logic                  w_last,
  output logic                  w_data_ready,
  output logic                  b_valid,
  input  logic                  b_ready
);

  localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
  localparam logic [3:0] B_LAT_C  = 4'(B_LAT);

  state_e                state, state_nxt;
  logic [AW-1:0]         addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic [3:0]            lat_cnt;
  logic                  w_over;
  logic                  r_hs, w_hs, beat_is_last;
  logic [WORD_BYTES-1:0] ram_we;
  logic [31:0]           ram_rdata;
  logic                  unused_bits;

  // Narrow sizes still move whole words and high address bits alias,
  // so these inputs carry no information for the responder.
  assign unused_bits = ^{r_addr[31:AW+2], r_addr[1:0], w_addr[31:AW+2], w_addr[1:0],
                         r_size == SIZE_WORD, w_size == SIZE_WORD};

  assign r_hs         = (state == S_R_BEAT) && r_data_ready;
  assign w_hs         = (state == S_W_BEAT) && w_data_req;
  assign beat_is_last = (beat_cnt == len_q);
  assign ram_we       = (w_hs && !w_over) ? w_strb : '0;

  resp_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (addr_q),
    .wdata (w_data),
    .raddr (addr_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Write is checked first so a writeback always lands before a refill of the same line.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (w_req)      state_nxt = S_W_BEAT;
        else if (r_req) state_nxt = S_R_WAIT;
      end
      S_R_WAIT: if (lat_cnt == 4'd0) state_nxt = S_R_BEAT;
      S_R_BEAT: if (r_hs && beat_is_last) state_nxt = S_IDLE;
      S_W_BEAT: if (w_hs && w_last) state_nxt = (B_LAT_C == 4'd0) ? S_B_RESP : S_B_WAIT;
      S_B_WAIT: if (lat_cnt <= 4'd1) state_nxt = S_B_RESP;
      S_B_RESP: if (b_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ret_valid    = 1'b0;
    ret_last     = 1'b0;
    r_data       = '0;
    w_data_ready = 1'b0;
    b_valid      = 1'b0;
    case (state)
      S_R_BEAT: begin
        ret_valid = 1'b1;
        ret_last  = beat_is_last;
        r_data    = ram_rdata;
      end
      S_W_BEAT: w_data_ready = 1'b1;
      S_B_RESP: b_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdy    <= 1'b0;
      w_rdy    <= 1'b0;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      w_over   <= 1'b0;
    end else begin
      w_rdy <= (state == S_IDLE) && w_req;
      r_rdy <= (state == S_IDLE) && !w_req && r_req;
      case (state)
        S_IDLE: begin
          beat_cnt <= '0;
          w_over   <= 1'b0;
          lat_cnt  <= RD_LAT_C;
        end
        S_R_WAIT: if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
        S_R_BEAT: if (r_hs) beat_cnt <= beat_cnt + 8'd1;
        S_W_BEAT: begin
          lat_cnt <= B_LAT_C;
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            // Beats past the requested length are still accepted, just not stored.
            if (beat_is_last) w_over <= 1'b1;
          end
        end
        S_B_WAIT: lat_cnt <= lat_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      if (w_req) begin
        addr_q <= w_addr[AW+1:2];
        len_q  <= w_length;
      end else if (r_req) begin
        addr_q <= r_addr[AW+1:2];
        len_q  <= r_length;
      end
    end else if (r_hs || w_hs) begin
      addr_q <= addr_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_axi_responder.sv
// Directed and randomized bench for dcache_axi_responder against a word-array memory model.
module tb_dcache_axi_responder;
  import dcache_axi_responder_pkg::*;

  localparam int AW     = 12;
  localparam int RD_LAT = 2;
  localparam int B_LAT  = 1;
  localparam int MEMW   = 1 << AW;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        r_req = 1'b0, r_data_ready = 1'b0;
  logic [31:0] r_addr = '0;
  logic [2:0]  r_size = SIZE_WORD;
  logic [7:0]  r_length = '0;
  logic        r_rdy, ret_valid, ret_last;
  logic [31:0] r_data;
  logic        w_req = 1'b0, w_data_req = 1'b0, w_last = 1'b0, b_ready = 1'b0;
  logic [31:0] w_addr = '0, w_data = '0;
  logic [2:0]  w_size = SIZE_WORD;
  logic [7:0]  w_length = '0;
  logic [3:0]  w_strb = '0;
  logic        w_rdy, w_data_ready, b_valid;

  always #5 clk = ~clk;

  dcache_axi_responder #(.AW(AW), .RD_LAT(RD_LAT), .B_LAT(B_LAT)) dut (
    .clk(clk), .rstn(rstn),
    .r_req(r_req), .r_addr(r_addr), .r_size(r_size), .r_length(r_length), .r_rdy(r_rdy),
    .r_data_ready(r_data_ready), .ret_valid(ret_valid), .ret_last(ret_last), .r_data(r_data),
    .w_req(w_req), .w_addr(w_addr), .w_size(w_size), .w_length(w_length), .w_rdy(w_rdy),
    .w_data_req(w_data_req), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .w_data_ready(w_data_ready), .b_valid(b_valid), .b_ready(b_ready)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [MEMW];
  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];
  logic [31:0] first_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] m;
    m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old & ~m) | (nw & m);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ret_valid"}, 32'(ret_valid), 32'd0);
    check({tag, "_ret_last"}, 32'(ret_last), 32'd0);
    check({tag, "_r_data"}, r_data, 32'd0);
    check({tag, "_r_rdy"}, 32'(r_rdy), 32'd0);
    check({tag, "_w_rdy"}, 32'(w_rdy), 32'd0);
    check({tag, "_w_data_ready"}, 32'(w_data_ready), 32'd0);
    check({tag, "_b_valid"}, 32'(b_valid), 32'd0);
  endtask

  // Write burst of nbeats taken from wdat/wstb; w_last on the final beat.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                          input bit hold_read);
    int cyc;
    int base;
    base = int'(addr[AW+1:2]);
    w_req = 1'b1; w_addr = addr; w_length = len; w_size = SIZE_WORD;
    if (hold_read) r_req = 1'b1;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!w_rdy && cyc < 64);
    check("w_rdy_grant", 32'(w_rdy), 32'd1);
    if (hold_read) check("r_rdy_loses", 32'(r_rdy), 32'd0);
    w_req = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      check("w_data_ready", 32'(w_data_ready), 32'd1);
      w_data_req = 1'b1; w_data = wdat[i]; w_strb = wstb[i]; w_last = (i == nbeats - 1);
      if (i <= int'(len)) model[(base + i) % MEMW] = merge(model[(base + i) % MEMW], wdat[i], wstb[i]);
      @(posedge clk); #1;
      if (i == 0) check("w_rdy_pulse", 32'(w_rdy), 32'd0);
      if (hold_read) check("r_rdy_blocked", 32'(r_rdy), 32'd0);
    end
    w_data_req = 1'b0; w_last = 1'b0; w_strb = '0;
    check("w_ready_drop", 32'(w_data_ready), 32'd0);
    cyc = 0;
    while (!b_valid && cyc < 64) begin @(posedge clk); #1; cyc++; end
    check("b_latency", 32'(cyc), 32'(B_LAT));
    repeat (2) begin @(posedge clk); #1; check("b_hold", 32'(b_valid), 32'd1); end
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
    check("b_done", 32'(b_valid), 32'd0);
  endtask

  // mode 0: always ready, 1: random backpressure, 2: ready pattern 1,0,0,1 then 1.
  // abort_beat >= 0 returns while that beat is presented.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int mode,
                         input int abort_beat);
    int cyc, base, t, k;
    logic rdy;
    base = int'(addr[AW+1:2]);
    r_req = 1'b1; r_addr = addr; r_length = len;
    r_size = (mode == 1) ? 3'($urandom_range(0, 2)) : SIZE_WORD;
    r_data_ready = 1'b0;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!r_rdy && cyc < 64);
    check("r_rdy_grant", 32'(r_rdy), 32'd1);
    r_req = 1'b0;
    cyc = 0;
    while (!ret_valid && cyc < 64) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) check("r_rdy_pulse", 32'(r_rdy), 32'd0);
    end
    check("rd_latency", 32'(cyc), 32'(RD_LAT + 1));
    t = 0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == abort_beat) return;
      k = 0;
      forever begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (k >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
          default: rdy = (t == 1 || t == 2) ? 1'b0 : 1'b1;
        endcase
        r_data_ready = rdy;
        check("ret_valid", 32'(ret_valid), 32'd1);
        check("r_data", r_data, model[(base + b) % MEMW]);
        check("ret_last", 32'(ret_last), 32'(b == int'(len)));
        if (b == 0) first_rdata = r_data;
        @(posedge clk); #1;
        t++; k++;
        if (rdy) break;
      end
    end
    r_data_ready = 1'b0;
    check("ret_valid_drop", 32'(ret_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int len, nb;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Fill the whole RAM with maximum-length bursts so every read has a known model value.
    for (int line = 0; line < MEMW / 256; line++) begin
      for (int i = 0; i < 256; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
      do_write(32'(line * 1024), 8'd255, 256, 1'b0);
    end

    // Line refill.
    for (int i = 0; i < LINE_BEATS; i++) begin wdat[i] = 32'h100 + 32'(i); wstb[i] = 4'hF; end
    do_write(32'h100, LINE_LEN, LINE_BEATS, 1'b0);
    do_read(32'h100, LINE_LEN, 0, -1);
    check("refill_first", first_rdata, 32'h100);

    // Writeback burst.
    for (int i = 0; i < LINE_BEATS; i++) begin wdat[i] = 32'hA0 + 32'(i); wstb[i] = 4'hF; end
    do_write(32'h200, LINE_LEN, LINE_BEATS, 1'b0);
    do_read(32'h23C, 8'd0, 0, -1);
    check("writeback_last", first_rdata, 32'hAF);

    // Uncached byte store.
    wdat[0] = 32'h11223344; wstb[0] = 4'hF;
    do_write(32'h4, 8'd0, 1, 1'b0);
    wdat[0] = 32'h00AA0000; wstb[0] = 4'b0100;
    do_write(32'h6, 8'd0, 1, 1'b0);
    do_read(32'h4, 8'd0, 0, -1);
    check("byte_store", first_rdata, 32'h11AA3344);

    // Simultaneous requests to the same line, read stalled 1,0,0,1.
    for (int i = 0; i < LINE_BEATS; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    r_addr = 32'h300; r_length = LINE_LEN;
    do_write(32'h300, LINE_LEN, LINE_BEATS, 1'b1);
    do_read(32'h300, LINE_LEN, 2, -1);
    check("simul_first", first_rdata, wdat[0]);

    // Wrap at the top of RAM, plus an aliased address.
    do_read(32'h3FFC, 8'd1, 0, -1);
    do_read(32'hABC1_3FFC, 8'd1, 1, -1);

    // Early w_last and beats past w_length, with a zero-strobe beat.
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hC0DE_0000 + 32'(i); wstb[i] = 4'hF; end
    do_write(32'h400, 8'd3, 2, 1'b0);
    do_read(32'h400, 8'd3, 1, -1);
    wstb[0] = 4'h0;
    do_write(32'h500, 8'd1, 4, 1'b0);
    do_read(32'h500, 8'd3, 1, -1);

    // Reset while beat 5 of a read is presented.
    do_read(32'h100, LINE_LEN, 0, 4);
    check("pre_reset_valid", 32'(ret_valid), 32'd1);
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    rstn = 1'b1;
    do_read(32'h100, LINE_LEN, 1, -1);

    // Randomized traffic over the full (aliasing) address space.
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 3) : len + 1;
        for (int i = 0; i < nb; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom_range(0, 15)); end
        do_write(a, 8'(len), nb, 1'b0);
      end else begin
        do_read(a, 8'(len), 1, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
